calc_result_display: RTL and testbench

//  Display end of the calculator datapath. Accepts a 9-bit two's-complement value
//  (operand echo or result) with a valid strobe. Converts it to sign + 3 BCD digits

---
 rtl/calc_result_display.sv | 131 +++++++++++++
 tb/tb_calc_result_display.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/calc_result_display.sv
// Display end of the calculator: 9-bit two's-complement value -> sign + 3 BCD digits
// (sequential double-dabble) -> 4-digit multiplexed active-low 7-segment display.
//
// state   | meaning
// IDLE    | waiting for value_valid, display shows last latched number
// CONVERT | 9 add-3/shift steps on {bcd,mag}
// LATCH   | glyphs with leading-zero suppression copied to display regs, done pulse
module calc_result_display #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] value,
    input  logic       value_valid,
    input  logic       blank,
    output logic       busy,
    output logic       done,
    output logic [3:0] anode,
    output logic [6:0] seg
);
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
    localparam logic [6:0] GLYPH_MINUS = 7'b0111111;

    typedef enum logic [1:0] {IDLE, CONVERT, LATCH} state_t;

    state_t            state, state_nxt;
    logic              neg;
    logic [8:0]        mag;
    logic [11:0]       bcd, bcd_adj;
    logic [3:0]        bit_cnt;
    logic [3:0][6:0]   disp;
    logic [CNT_W-1:0]  refresh_cnt;
    logic [1:0]        scan_idx;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return GLYPH_BLANK;
        endcase
    endfunction

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 3; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (value_valid) state_nxt = CONVERT;
            CONVERT: if (bit_cnt == 4'd8) state_nxt = LATCH;
            LATCH:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            neg     <= 1'b0;
            mag     <= '0;
            bcd     <= '0;
            bit_cnt <= '0;
            done    <= 1'b0;
            disp    <= {4{GLYPH_BLANK}};
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (value_valid) begin
                        neg     <= value[8];
                        // -256 negates to 9'h100, which reads as 256 unsigned
                        mag     <= value[8] ? (~value + 9'd1) : value;
                        bcd     <= '0;
                        bit_cnt <= '0;
                    end
                end
                CONVERT: begin
                    {bcd, mag} <= {bcd_adj, mag} << 1;
                    bit_cnt    <= bit_cnt + 4'd1;
                end
                LATCH: begin
                    disp[3] <= neg ? GLYPH_MINUS : GLYPH_BLANK;
                    disp[2] <= (bcd[11:8] == 4'd0) ? GLYPH_BLANK : glyph(bcd[11:8]);
                    disp[1] <= (bcd[11:8] == 4'd0 && bcd[7:4] == 4'd0) ? GLYPH_BLANK
                                                                       : glyph(bcd[7:4]);
                    disp[0] <= glyph(bcd[3:0]);
                    done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_cnt <= '0;
            scan_idx    <= '0;
            anode       <= 4'b1111;
            seg         <= GLYPH_BLANK;
        end else begin
            if (refresh_cnt == CNT_LAST) begin
                refresh_cnt <= '0;
                scan_idx    <= scan_idx + 2'd1;
            end else begin
                refresh_cnt <= refresh_cnt + CNT_W'(1);
            end
            anode <= blank ? 4'b1111 : ~(4'b0001 << scan_idx);
            seg   <= disp[scan_idx];
        end
    end
endmodule

// File: tb/tb_calc_result_display.sv
// Scoreboard bench for calc_result_display: expected display images are queued at
// strobe time and compared when done fires, by decoding the scanned anode/seg pins.
module tb_calc_result_display;
    localparam logic [6:0] G_BLANK = 7'b1111111;
    localparam logic [6:0] G_MINUS = 7'b0111111;

    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] value;
    logic       value_valid;
    logic       blank;
    logic       busy;
    logic       done;
    logic [3:0] anode;
    logic [6:0] seg;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ready_cyc = 0;
    logic [27:0] sb_q[$];

    calc_result_display #(.REFRESH_DIV(4)) dut (
        .clk(clk), .reset(reset), .value(value), .value_valid(value_valid),
        .blank(blank), .busy(busy), .done(done), .anode(anode), .seg(seg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] exp_glyph(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return G_BLANK;
        endcase
    endfunction

    function automatic logic [27:0] exp_disp(input int v);
        int m, h, t, o;
        logic [6:0] sg, hg, tg;
        m  = (v < 0) ? -v : v;
        h  = m / 100;
        t  = (m / 10) % 10;
        o  = m % 10;
        sg = (v < 0) ? G_MINUS : G_BLANK;
        hg = (h == 0) ? G_BLANK : exp_glyph(h);
        tg = (h == 0 && t == 0) ? G_BLANK : exp_glyph(t);
        return {sg, hg, tg, exp_glyph(o)};
    endfunction

    // Strobe sampled on the next edge; the model knows when the DUT can accept.
    task automatic drive(input int v);
        value       = 9'(v);
        value_valid = 1'b1;
        if (cyc + 1 >= ready_cyc) begin
            sb_q.push_back(exp_disp(v));
            ready_cyc = cyc + 12;
        end
        tick();
        value_valid = 1'b0;
    endtask

    task automatic read_display(output logic [27:0] got);
        logic [3:0] seen;
        seen = 4'b0000;
        got  = '1;
        for (int i = 0; i < 40 && seen != 4'hF; i++) begin
            tick();
            case (anode)
                4'b1110: begin got[6:0]   = seg; seen[0] = 1'b1; end
                4'b1101: begin got[13:7]  = seg; seen[1] = 1'b1; end
                4'b1011: begin got[20:14] = seg; seen[2] = 1'b1; end
                4'b0111: begin got[27:21] = seg; seen[3] = 1'b1; end
                default: ;
            endcase
        end
        chk("scan_cover", 32'(seen), 32'hF);
    endtask

    task automatic wait_done_and_compare(input string tag);
        bit          seen_done;
        logic [27:0] got, exp;
        seen_done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done === 1'b1) begin
                seen_done = 1'b1;
                break;
            end
        end
        chk({tag, "_done"}, 32'(seen_done), 32'd1);
        if (seen_done) begin
            chk({tag, "_sb_pending"}, 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                exp = sb_q.pop_front();
                read_display(got);
                chk(tag, 32'(got), 32'(exp));
            end
        end
    endtask

    initial begin
        int          busy_bad, done_bad, n_done, t, idx0, bad;
        logic [27:0] got, exp;
        logic [3:0]  a0, ea;

        reset = 1'b1; value = '0; value_valid = 1'b0; blank = 1'b0;
        tick();
        tick();
        chk("rst_anode", 32'(anode), 32'hF);
        chk("rst_seg",   32'(seg),   32'h7F);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_done",  32'(done),  32'd0);
        reset = 1'b0;
        ready_cyc = cyc + 1;

        // exact latency of one conversion
        busy_bad = 0; done_bad = 0;
        drive(123);
        for (int k = 0; k < 10; k++) begin
            if (busy !== 1'b1) busy_bad++;
            if (done !== 1'b0) done_bad++;
            tick();
        end
        chk("busy_n_to_n9", 32'(busy_bad), 32'd0);
        chk("done_early",   32'(done_bad), 32'd0);
        chk("done_n10",     32'(done), 32'd1);
        chk("busy_n10",     32'(busy), 32'd0);
        exp = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
        tick();
        chk("done_one_cycle", 32'(done), 32'd0);
        read_display(got);
        chk("disp_123", 32'(got), 32'(exp));

        drive(-5);   wait_done_and_compare("disp_m5");
        drive(-256); wait_done_and_compare("disp_m256");
        drive(0);    wait_done_and_compare("disp_0");
        drive(105);  wait_done_and_compare("disp_105");
        drive(10);   wait_done_and_compare("disp_10");
        drive(-99);  wait_done_and_compare("disp_m99");

        // second strobe while busy must be dropped
        drive(255);
        tick(); tick(); tick();
        drive(7);
        n_done = 0;
        exp = '0;
        for (int k = 0; k < 14; k++) begin
            tick();
            if (done === 1'b1) begin
                n_done++;
                if (sb_q.size() != 0) exp = sb_q.pop_front();
            end
        end
        chk("busy_drop_done_cnt", 32'(n_done), 32'd1);
        chk("busy_drop_sb_empty", 32'(sb_q.size()), 32'd0);
        read_display(got);
        chk("disp_255", 32'(got), 32'(exp));

        // scan rotation period and blanking
        drive(42); wait_done_and_compare("disp_42");
        a0 = anode;
        t = 0;
        while (anode === a0 && t < 10) begin
            tick();
            t++;
        end
        chk("scan_advances", 32'(anode !== a0), 32'd1);
        idx0 = 0;
        for (int i = 0; i < 4; i++) if (anode[i] === 1'b0) idx0 = i;
        bad = 0;
        for (int i = 1; i < 16; i++) begin
            tick();
            ea = ~(4'b0001 << ((idx0 + i / 4) % 4));
            if (anode !== ea) bad++;
        end
        chk("scan_period", 32'(bad), 32'd0);
        blank = 1'b1;
        tick();
        chk("blank_next_edge", 32'(anode), 32'hF);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (anode !== 4'hF) bad++;
        end
        chk("blank_held", 32'(bad), 32'd0);
        blank = 1'b0;
        tick();
        chk("unblank_next_edge", 32'(anode === 4'hF), 32'd0);
        read_display(got);
        chk("disp_42_after_blank", 32'(got), 32'(exp_disp(42)));

        // reset in the middle of a conversion
        drive(99);
        tick(); tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb_q.delete();
        ready_cyc = cyc + 1;
        chk("abort_busy",  32'(busy),  32'd0);
        chk("abort_anode", 32'(anode), 32'hF);
        n_done = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done === 1'b1) n_done++;
        end
        chk("abort_no_done", 32'(n_done), 32'd0);
        read_display(got);
        chk("abort_disp_blank", 32'(got), 32'(28'hFFFFFFF));
        drive(-42); wait_done_and_compare("disp_m42_after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
